axi_lite_arbiter: RTL
=====================

# axi_lite_arbiter

Round-robin arbiter that shares one AXI4-Lite master command port (transact / read_or_write / addr / write_data / read_data / transaction_complete) among NUM_REQ requesters, e.g. the heater-pattern controller, temperature poller and host CSR bridge. It accepts one request at a time and sequences the master's level-based transact handshake. It returns read data and a one-cycle response pulse to the winning requester. Sits directly between the requesters and the AXI master in the HBM register path.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 11, AXI-Lite address width
- DATA_W, 32, data width

Ports:
- axi_aclk  in  1  sole clock
- axi_aresetn  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request; hold with fields stable until req_ready
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot accept pulse
- resp_valid  out  NUM_REQ  one-hot completion pulse
- resp_rdata  out  DATA_W  read data, valid with resp_valid; shared by all requesters
- busy  out  1  high whenever state is not IDLE
- transact  out  1  to master
- read_or_write  out  1  to master; 1 = write
- addr  out  ADDR_W  to master
- write_data  out  DATA_W  to master
- read_data  in  DATA_W  from master
- transaction_complete  in  1  from master

## Operation
- States: IDLE, ISSUE, RELEASE.
- IDLE:
  - If any req_valid is high, the picker selects winner w and req_ready[w] is driven high combinationally for that cycle.
  - On that edge, register w, req_we[w], addr and wdata into the master-side outputs.
  - Update last_grant to w and move to ISSUE.
- ISSUE:
  - transact = 1; read_or_write, addr and write_data are held constant.
  - On the first cycle with transaction_complete = 1: capture read_data into resp_rdata, pulse resp_valid[w] on the next cycle, and go to RELEASE.
  - For writes, resp_rdata is still loaded with read_data; its content is don't-care.
- RELEASE:
  - transact = 0.
  - Stay until transaction_complete = 0, then go to IDLE.
  - A new transact is never raised while transaction_complete is high.
- Arbitration: search order starts at (last_grant+1) mod NUM_REQ and wraps. Requesters whose req_valid is low are skipped.
- Requests arriving while busy are held by the requester. They are not queued internally.
- resp_valid is a single-cycle pulse. The requester must latch resp_rdata in that cycle.

## Timing
- Reset values: transact 0, read_or_write 0, addr 0, write_data 0, req_ready 0 (combinational, gated by state = IDLE), resp_valid 0, resp_rdata 0, busy 0, state IDLE, last_grant NUM_REQ-1 (so requester 0 wins first).
- Latency:
  - req_ready is asserted in the same cycle as req_valid when the arbiter is IDLE.
  - transact rises on the next edge.
  - resp_valid fires 1 cycle after the first cycle transaction_complete is seen high.
- Minimum spacing between consecutive transacts: ISSUE, then ≥1 RELEASE cycle, then 1 IDLE cycle.
- Simultaneous requests: exactly one winner per IDLE cycle, chosen by the round-robin rule.
- req_valid dropping before req_ready: the request is withdrawn and no transaction is issued.
- Reset mid-transaction: all outputs return to reset values on the next edge and no resp_valid is produced. Requesters and the master are reset by the same axi_aresetn.
- The wait in ISSUE is unbounded; there is no timeout.

## Configuration
- AXI_ARB_ROUND_ROBIN_EN defined: round-robin search as described above.
- Undefined: fixed priority, where the lowest-index valid requester always wins. last_grant is still registered but does not affect selection.

## Structure
- Package hbm_axi_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, RELEASE}
  - localparams AXI_ADDR_W = 11, AXI_DATA_W = 32, used as the parameter defaults
- Sub-module rr_picker:
  - Purely combinational.
  - Inputs: req vector, last_grant. Outputs: one-hot grant and its index.
  - The macro is resolved inside it.

## Test plan
- Single read, requester 2, addr 0x1A4. Master model returns 0xCAFE_0001 after 5 cycles → transact high 5 cycles; resp_valid[2] pulse with resp_rdata = 0xCAFE_0001; then busy = 0.
- Single write, requester 0, addr 0x010, data 0x1234_5678 → read_or_write = 1, addr = 0x010 and write_data = 0x1234_5678 stable throughout ISSUE; resp_valid[0] pulse.
- All four requesters hold req_valid continuously (round robin) → grant order 0, 1, 2, 3, 0, 1. With the macro undefined → 0, 0, 0, …
- transaction_complete held high for 3 cycles after transact drops → arbiter stays in RELEASE; the next transact does not rise until 1 cycle after complete falls.
- axi_aresetn low for 1 cycle while in ISSUE → transact = 0 on the next edge; no resp_valid; next request to requester 0 is granted normally.
- req_valid[1] raised while busy and then withdrawn before IDLE → no req_ready[1] and no transaction issued.

Source files
------------

// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and defaults for the HBM register-path AXI-Lite arbiter.
// State encoding, default bus widths and the wrap-around index helper.
package hbm_axi_arb_pkg;

  localparam int AXI_ADDR_W = 11;
  localparam int AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // base < n and off <= n, so one subtraction is enough to wrap.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/axi_lite_arbiter_picker.sv
// Request picker: round-robin from last_grant+1 with AXI_ARB_ROUND_ROBIN_EN, else lowest index wins.
// Latency: purely combinational. Backpressure: none, grant follows req in the same cycle.
// A zero req vector yields a zero grant and index 0.
module rr_picker
  import hbm_axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found   = 1'b0;
    cand    = '0;
    gnt     = '0;
    gnt_idx = '0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'(wrap_idx(int'(last_grant), off, NUM_REQ));
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'(i);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
`endif
    if (found) gnt[gnt_idx] = 1'b1;
  end

`ifndef AXI_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; last_grant stays on the port for a uniform interface.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI-Lite master command port among NUM_REQ requesters (AXI_ARB_ROUND_ROBIN_EN selects round robin).
// Latency: req_ready same cycle as req_valid in IDLE, transact next edge, resp_valid 1 cycle after first complete.
// Backpressure: requesters hold req_valid while busy; nothing is queued, the master wait is unbounded.
module axi_lite_arbiter
  import hbm_axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = AXI_ADDR_W,
  parameter int DATA_W  = AXI_DATA_W
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      busy,
  output logic                      transact,
  output logic                      read_or_write,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         write_data,
  input  logic [DATA_W-1:0]         read_data,
  input  logic                      transaction_complete
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .gnt_idx    (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready    = pick_gnt;
          last_grant_d = pick_idx;
          rw_d         = req_we[pick_idx];
          addr_d       = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_d      = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // read_data is captured for writes too; the requester ignores it.
        if (transaction_complete) begin
          resp_rdata_d = read_data;
          resp_valid_d = NUM_REQ'(1) << last_grant_q;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        // Holding here until complete drops keeps the next transact off a stale complete.
        if (!transaction_complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign transact      = (state_q == ISSUE);
  assign busy          = (state_q != IDLE);
  assign read_or_write = rw_q;
  assign addr          = addr_q;
  assign write_data    = wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;

endmodule
